// File: rtl/ins_cache.sv
// Direct-mapped read-only instruction cache: one-word lines, byte-wide refill port.
// Optional macro ICACHE_FLUSH_EN adds a 'flush' input that invalidates every line.
module ins_cache #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fetch_call,
  input  logic [ADDR_W-1:0] fetch_addr,
`ifdef ICACHE_FLUSH_EN
  input  logic              flush,
`endif
  output logic              ins_ok,
  output logic [31:0]       ins_out,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_a,
  input  logic              mem_gnt,
  input  logic [7:0]        mem_din
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q;
  logic [31:0]       data_mem [LINES];
  logic [TAG_W-1:0]  tag_mem  [LINES];

  logic [IDX_W-1:0]  req_idx_q;
  logic [TAG_W-1:0]  req_tag_q;
  logic [2:0]        iss_cnt_q, iss_cnt_d;
  logic [1:0]        rcv_cnt_q, rcv_cnt_d;
  logic              issued_q, issued_d;
  logic [2:0][7:0]   byte_q, byte_d;

  logic              ins_ok_d, busy_d, mem_req_d;
  logic [31:0]       ins_out_d;
  logic [ADDR_W-1:0] mem_a_d;
  logic              line_we, valid_clr, latch_req;

  logic [IDX_W-1:0]  call_idx;
  logic [TAG_W-1:0]  call_tag;
  logic              hit;
  logic [31:0]       fill_word;

  // Fetches are word-aligned; the low two address bits carry no information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^fetch_addr[1:0];

  assign call_idx  = fetch_addr[IDX_W+1:2];
  assign call_tag  = fetch_addr[ADDR_W-1:IDX_W+2];
  assign hit       = valid_q[call_idx] && (tag_mem[call_idx] == call_tag);
  // The last byte is used straight off the RAM bus so the line completes on its capture edge.
  assign fill_word = {mem_din, byte_q[2], byte_q[1], byte_q[0]};

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    ins_ok_d  = 1'b0;
    ins_out_d = ins_out;
    busy_d    = busy;
    mem_req_d = mem_req;
    mem_a_d   = mem_a;
    iss_cnt_d = iss_cnt_q;
    rcv_cnt_d = rcv_cnt_q;
    issued_d  = 1'b0;
    byte_d    = byte_q;
    line_we   = 1'b0;
    valid_clr = 1'b0;
    latch_req = 1'b0;

    case (state_q)
      IDLE: begin
        if (fetch_call) begin
          latch_req = 1'b1;
          if (hit) begin
            ins_out_d = data_mem[call_idx];
            ins_ok_d  = 1'b1;
          end else begin
            busy_d    = 1'b1;
            mem_req_d = 1'b1;
            mem_a_d   = {fetch_addr[ADDR_W-1:2], 2'b00};
            iss_cnt_d = 3'd0;
            rcv_cnt_d = 2'd0;
            state_d   = REFILL;
          end
        end
      end
      REFILL: begin
        if (mem_req && mem_gnt) begin
          issued_d  = 1'b1;
          mem_a_d   = mem_a + ADDR_W'(1);
          iss_cnt_d = iss_cnt_q + 3'd1;
          if (iss_cnt_q == 3'd3) mem_req_d = 1'b0;
        end
        if (issued_q) begin
          if (rcv_cnt_q == 2'd3) begin
            line_we   = 1'b1;
            ins_out_d = fill_word;
            ins_ok_d  = 1'b1;
            busy_d    = 1'b0;
            state_d   = RESP;
          end else begin
            byte_d[rcv_cnt_q] = mem_din;
            rcv_cnt_d         = rcv_cnt_q + 2'd1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef ICACHE_FLUSH_EN
    // Flush wins over any refill or hit in the same cycle.
    if (flush) begin
      state_d   = IDLE;
      ins_ok_d  = 1'b0;
      ins_out_d = ins_out;
      busy_d    = 1'b0;
      mem_req_d = 1'b0;
      issued_d  = 1'b0;
      line_we   = 1'b0;
      latch_req = 1'b0;
      valid_clr = 1'b1;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ins_ok    <= 1'b0;
      ins_out   <= '0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_a     <= '0;
      valid_q   <= '0;
      iss_cnt_q <= '0;
      rcv_cnt_q <= '0;
      issued_q  <= 1'b0;
    end else if (en) begin
      state_q   <= state_d;
      ins_ok    <= ins_ok_d;
      ins_out   <= ins_out_d;
      busy      <= busy_d;
      mem_req   <= mem_req_d;
      mem_a     <= mem_a_d;
      iss_cnt_q <= iss_cnt_d;
      rcv_cnt_q <= rcv_cnt_d;
      issued_q  <= issued_d;
      if (valid_clr)    valid_q            <= '0;
      else if (line_we) valid_q[req_idx_q] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays and the byte buffer are never reset; valid_q alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (en && !rst) begin
      if (latch_req) begin
        req_idx_q <= call_idx;
        req_tag_q <= call_tag;
      end
      byte_q <= byte_d;
      if (line_we) begin
        data_mem[req_idx_q] <= fill_word;
        tag_mem[req_idx_q]  <= req_tag_q;
      end
    end
  end

endmodule

// File: tb/tb_ins_cache.sv
// Self-checking bench for ins_cache: RAM model, issued-address monitor and a response scoreboard.
module tb_ins_cache;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = 6;

  logic              clk = 1'b0;
  logic              rst, en, fetch_call, mem_gnt;
  logic [ADDR_W-1:0] fetch_addr;
  logic              ins_ok, busy, mem_req;
  logic [31:0]       ins_out;
  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_din = 8'h00;
`ifdef ICACHE_FLUSH_EN
  logic              flush = 1'b0;
`endif

  logic [7:0]  ram [1024];
  logic [31:0] sb_q [$];
  logic [31:0] iss_log [$];
  int n_tests = 0;
  int n_fail  = 0;

  ins_cache #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .en(en),
    .fetch_call(fetch_call), .fetch_addr(fetch_addr),
`ifdef ICACHE_FLUSH_EN
    .flush(flush),
`endif
    .ins_ok(ins_ok), .ins_out(ins_out), .busy(busy),
    .mem_req(mem_req), .mem_a(mem_a), .mem_gnt(mem_gnt), .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  // RAM returns the byte the cycle after the address is issued; stalls with en.
  always @(posedge clk) if (en && mem_req && mem_gnt) mem_din <= ram[mem_a[9:0]];
  always @(posedge clk) if (!rst && en && mem_req && mem_gnt) iss_log.push_back(mem_a);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    logic [9:0] a;
    a = {addr[9:2], 2'b00};
    return {ram[a + 10'd3], ram[a + 10'd2], ram[a + 10'd1], ram[a]};
  endfunction

  task automatic pop_check(input string tag);
    if (sb_q.size() == 0) check({tag, "_unexpected_ok"}, {31'b0, ins_ok}, 32'd0);
    else check({tag, "_data"}, ins_out, sb_q.pop_front());
  endtask

  // exp_edge: index of the edge (call edge = 0) after which ins_ok is seen.
  task automatic do_fetch(input string name, input logic [31:0] addr, input int exp_edge,
                          input logic [15:0] gnt_pat);
    int k, busy_cnt, req_cnt;
    bit seen;
    logic [31:0] base;
    base = {addr[31:2], 2'b00};
    sb_q.push_back(word_at(addr));
    iss_log.delete();
    fetch_call = 1'b1; fetch_addr = addr; mem_gnt = 1'b0;
    step();
    fetch_call = 1'b0;
    k = 0; busy_cnt = 0; req_cnt = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      if (busy) busy_cnt++;
      if (mem_req) req_cnt++;
      if (ins_ok) seen = 1'b1;
      else begin
        mem_gnt = (k < 16) ? gnt_pat[k] : 1'b1;
        step();
        k++;
      end
    end
    if (!seen) check({name, "_timeout"}, {31'b0, ins_ok}, 32'd1);
    else begin
      check({name, "_latency"}, 32'(k), 32'(exp_edge));
      pop_check(name);
      check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_edge));
      if (exp_edge == 0) begin
        check({name, "_hit_no_req"}, 32'(req_cnt), 32'd0);
        check({name, "_hit_no_issue"}, 32'(iss_log.size()), 32'd0);
      end else begin
        check({name, "_issue_count"}, 32'(iss_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < iss_log.size(); i++)
          check({name, "_issue_addr"}, iss_log[i], base + 32'(i));
      end
      mem_gnt = 1'b0;
      step();
      check({name, "_ok_pulse"}, {31'b0, ins_ok}, 32'd0);
      check({name, "_busy_after"}, {31'b0, busy}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ok_cnt, k;
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i * 37 + 11);
    ram[16] = 8'h13; ram[17] = 8'h05; ram[18] = 8'h10; ram[19] = 8'h00;

    rst = 1'b1; en = 1'b1; fetch_call = 1'b0; fetch_addr = '0; mem_gnt = 1'b0;
    repeat (3) step();
    check("rst_ins_ok", {31'b0, ins_ok}, 32'd0);
    check("rst_ins_out", ins_out, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    rst = 1'b0;
    step();

    check("ram_word_0x10", word_at(32'h10), 32'h0010_0513);
    do_fetch("cold_miss", 32'h10, 5, 16'hFFFF);
    do_fetch("hit", 32'h10, 0, 16'hFFFF);
    do_fetch("conflict", 32'h110, 5, 16'hFFFF);
    do_fetch("conflict_back", 32'h10, 5, 16'hFFFF);
    // Grant pattern 1,0,0,1,1,0,1: issues on edges 1,4,5,7; last capture on edge 8.
    do_fetch("gnt_gaps", 32'h40, 8, 16'h0059);
    do_fetch("gaps_hit_unaligned", 32'h43, 0, 16'hFFFF);

    // Reset after two bytes have been issued.
    iss_log.delete();
    fetch_call = 1'b1; fetch_addr = 32'h20;
    step();
    fetch_call = 1'b0; mem_gnt = 1'b1;
    step(); step();
    check("mr_issued", 32'(iss_log.size()), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr_ins_ok", {31'b0, ins_ok}, 32'd0);
    check("mr_ins_out", ins_out, 32'd0);
    check("mr_busy", {31'b0, busy}, 32'd0);
    check("mr_mem_req", {31'b0, mem_req}, 32'd0);
    check("mr_mem_a", mem_a, 32'd0);
    ok_cnt = 0;
    repeat (8) begin step(); if (ins_ok) ok_cnt++; end
    check("mr_no_ok", 32'(ok_cnt), 32'd0);
    do_fetch("mr_refetch", 32'h20, 5, 16'hFFFF);

    // en low for three cycles after two bytes issued: everything holds, no byte lost.
    sb_q.push_back(word_at(32'h50));
    fetch_call = 1'b1; fetch_addr = 32'h50; mem_gnt = 1'b1;
    step();
    fetch_call = 1'b0;
    step(); step();
    en = 1'b0;
    repeat (3) step();
    check("en_hold_mem_a", mem_a, 32'h52);
    check("en_hold_busy", {31'b0, busy}, 32'd1);
    check("en_hold_ok", {31'b0, ins_ok}, 32'd0);
    en = 1'b1;
    k = 0;
    while (!ins_ok && k < 20) begin step(); k++; end
    check("en_resume_edges", 32'(k), 32'd3);
    if (ins_ok) pop_check("en_resume");
    mem_gnt = 1'b0;
    step();
    do_fetch("en_hit", 32'h50, 0, 16'hFFFF);

`ifdef ICACHE_FLUSH_EN
    do_fetch("fl_hit", 32'h10, 0, 16'hFFFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    do_fetch("fl_miss", 32'h10, 5, 16'hFFFF);
    fetch_call = 1'b1; fetch_addr = 32'h30;
    step();
    fetch_call = 1'b0; mem_gnt = 1'b1;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_abort_ok", {31'b0, ins_ok}, 32'd0);
    check("fl_abort_busy", {31'b0, busy}, 32'd0);
    check("fl_abort_req", {31'b0, mem_req}, 32'd0);
    ok_cnt = 0;
    repeat (8) begin step(); if (ins_ok) ok_cnt++; end
    check("fl_abort_no_ok", 32'(ok_cnt), 32'd0);
    mem_gnt = 1'b0;
    do_fetch("fl_refetch", 32'h30, 5, 16'hFFFF);
`endif

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
